// File: rtl/div_result_buf.sv
// div_result_buf
//
// Result stage for the free-running pipelined divider `div`. It wraps the divider in a
// valid/ready handshake. Each accepted operand pair is tracked through the divider's fixed
// latency by a valid delay line. The quotient/remainder that emerge are captured into a
// first-word fall-through FIFO. A credit counter limits issue so that every in-flight result
// is guaranteed a FIFO slot when it arrives.
//
// Optional feature: define DIV_DBZ_EN to add a per-result divide-by-zero flag. The flag is
// (divisor == 0) sampled at accept, carried alongside the valid bit, stored per entry and
// presented on out_dbz. When DIV_DBZ_EN is undefined, out_dbz is tied 0 and divisor is
// ignored.
//
// Parameters:
//   N      data width; must match the companion div
//   LAT    divider latency in cycles
//   DEPTH  FIFO entries; power of two, >= 2; full throughput needs DEPTH >= LAT+2
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   in_valid       operand pair is on the divider inputs this cycle
//   in_ready       an operation can be accepted this cycle (registered state only)
//   divisor        divisor driven to div; used only for the divide-by-zero flag
//   quotient       div quotient output
//   remainder      div remainder output
//   out_valid      FIFO head holds a result
//   out_ready      sink takes the head
//   out_quotient   head quotient
//   out_remainder  head remainder
//   out_dbz        head was a divide-by-zero
//   level          FIFO occupancy, excluding in-flight operations

module div_result_buf #(
    parameter int unsigned N     = 8,
    parameter int unsigned LAT   = N,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               divisor,
    input  logic [N-1:0]               quotient,
    input  logic [N-1:0]               remainder,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_quotient,
    output logic [N-1:0]               out_remainder,
    output logic                       out_dbz,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] DepthL = LW'(DEPTH);
    localparam logic [LW-1:0] OneL   = LW'(1);

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic          accept;
    logic          pop;
    logic          wr;
    logic [LW-1:0] reserved_q, reserved_d;
    logic [LW-1:0] level_q, level_d;

    // in_ready comes only from the credit register, so out_ready never reaches it
    // combinationally.
    assign in_ready  = (reserved_q < DepthL);
    assign out_valid = (level_q != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Valid delay line: bit k set means an op accepted k+1 edges ago.
    // When the top bit is set, the divider outputs belong to that op.
    // ------------------------------------------------------------------
    logic [LAT-1:0] vld_q, vld_d;

    generate
        if (LAT == 1) begin : g_vld_one
            assign vld_d = accept;
        end else begin : g_vld_many
            assign vld_d = {vld_q[LAT-2:0], accept};
        end
    endgenerate

    assign wr = vld_q[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Credit counter: FIFO occupancy plus in-flight operations.
    // ------------------------------------------------------------------
    always_comb begin
        reserved_d = reserved_q;
        case ({accept, pop})
            2'b10:   reserved_d = reserved_q + OneL;
            2'b01:   reserved_d = reserved_q - OneL;
            default: reserved_d = reserved_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reserved_q <= '0;
        end else begin
            reserved_q <= reserved_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // DEPTH is a power of two, so natural pointer overflow gives the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr, pop})
            2'b10:   level_d = level_q + OneL;
            2'b01:   level_d = level_q - OneL;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign level = level_q;

    // ------------------------------------------------------------------
    // FIFO storage. Contents need no reset; out_valid qualifies them.
    // ------------------------------------------------------------------
    logic [N-1:0] q_mem [DEPTH];
    logic [N-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) begin
            q_mem[wr_ptr_q] <= quotient;
            r_mem[wr_ptr_q] <= remainder;
        end
    end

    assign out_quotient  = q_mem[rd_ptr_q];
    assign out_remainder = r_mem[rd_ptr_q];

`ifdef DIV_DBZ_EN
    // ------------------------------------------------------------------
    // Divide-by-zero flag, carried in parallel with the valid delay line.
    // ------------------------------------------------------------------
    logic [LAT-1:0] dbz_q, dbz_d;
    logic           dbz_in;
    logic           dbz_mem [DEPTH];

    assign dbz_in = accept && (divisor == '0);

    generate
        if (LAT == 1) begin : g_dbz_one
            assign dbz_d = dbz_in;
        end else begin : g_dbz_many
            assign dbz_d = {dbz_q[LAT-2:0], dbz_in};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_q <= '0;
        end else begin
            dbz_q <= dbz_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            dbz_mem[wr_ptr_q] <= dbz_q[LAT-1];
        end
    end

    // Gate with out_valid so the flag reads 0 out of reset and while empty.
    assign out_dbz = out_valid && dbz_mem[rd_ptr_q];
`else
    logic unused_divisor;
    assign unused_divisor = ^divisor;
    assign out_dbz        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    // A write never meets a full FIFO: its credit was taken at accept.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        wr |-> (level_q < DepthL));

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (reserved_q <= DepthL) && (level_q <= reserved_q));

endmodule

// File: tb/tb_div_result_buf.sv
module tb_div_result_buf;

    localparam int unsigned N     = 8;
    localparam int unsigned LAT   = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic [N-1:0]  quotient;
    logic [N-1:0]  remainder;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_quotient;
    logic [N-1:0]  out_remainder;
    logic          out_dbz;
    logic [LW-1:0] level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_result_buf #(
        .N     (N),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .divisor       (divisor),
        .quotient      (quotient),
        .remainder     (remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_dbz       (out_dbz),
        .level         (level)
    );

    // Behavioural stand-in for the free-running divider: LAT registered stages, no reset.
    logic [N-1:0] pq [LAT];
    logic [N-1:0] pr [LAT];

    always @(posedge clk) begin
        if (divisor == '0) begin
            pq[0] <= '1;
            pr[0] <= dividend;
        end else begin
            pq[0] <= dividend / divisor;
            pr[0] <= dividend % divisor;
        end
        for (int k = 1; k < LAT; k++) begin
            pq[k] <= pq[k-1];
            pr[k] <= pr[k-1];
        end
    end

    assign quotient  = pq[LAT-1];
    assign remainder = pr[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    logic [N-1:0] exp_q [$];
    logic [N-1:0] exp_r [$];
    logic [N-1:0] a, b;
    int accepts, rcv, drops, big_level, first_c, last_c;
    logic exp_dbz;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            dividend  = N'($urandom);
            divisor   = N'($urandom);
            #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_level", level, 0);
            chk("rst_out_dbz", out_dbz, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        step();

        // Single op: 100 / 7
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        step();                         // edge 1: accept
        in_valid = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            step();
            if (k == 8) chk("single_not_yet", out_valid, 0);
        end
        chk("single_valid", out_valid, 1);
        chk("single_q", out_quotient, 14);
        chk("single_r", out_remainder, 2);
        chk("single_level", level, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_pop_level", level, 0);
        chk("single_pop_valid", out_valid, 0);
        chk("single_reserved", dut.reserved_q, 0);
        chk("single_in_ready", in_ready, 1);

        // Backpressure: sink stalled, continuous issue
        accepts = 0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            a = N'(50 + i);
            b = N'(3 + (i % 5));
            dividend = a;
            divisor  = b;
            if (in_ready) begin
                accepts++;
                exp_q.push_back(a / b);
                exp_r.push_back(a % b);
            end
            step();
        end
        in_valid = 1'b0;
        repeat (LAT + 2) step();
        chk("bp_accepts", accepts, 16);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_level", level, 16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("bp_drain_valid", out_valid, 1);
            if (exp_q.size() != 0) begin
                chk("bp_drain_q", out_quotient, exp_q.pop_front());
                chk("bp_drain_r", out_remainder, exp_r.pop_front());
            end
            step();
        end
        chk("bp_empty_valid", out_valid, 0);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_level_zero", level, 0);

        // Throughput: 100 back-to-back random ops with sink always ready
        exp_q.delete();
        exp_r.delete();
        rcv = 0; drops = 0; big_level = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 100 + LAT + 2; c++) begin
            if (out_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                rcv++;
                if (exp_q.size() != 0) begin
                    chk("tp_q", out_quotient, exp_q.pop_front());
                    chk("tp_r", out_remainder, exp_r.pop_front());
                end
            end
            if (level > 1) big_level++;
            if (c < 100) begin
                if (!in_ready) drops++;
                a = N'($urandom_range(0, 255));
                b = N'($urandom_range(1, 255));
                in_valid = 1'b1;
                dividend = a;
                divisor  = b;
                exp_q.push_back(a / b);
                exp_r.push_back(a % b);
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        chk("tp_in_ready_drops", drops, 0);
        chk("tp_received", rcv, 100);
        chk("tp_consecutive", last_c - first_c, 99);
        chk("tp_first_latency", first_c, LAT + 1);
        chk("tp_level_peak", big_level, 0);
        chk("tp_level_end", level, 0);
        out_ready = 1'b0;

        // Divide by zero: 200 / 0
`ifdef DIV_DBZ_EN
        exp_dbz = 1'b1;
`else
        exp_dbz = 1'b0;
`endif
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd0;
        step();
        in_valid = 1'b0;
        divisor  = 8'd1;
        repeat (LAT) step();
        chk("dbz_valid", out_valid, 1);
        chk("dbz_q", out_quotient, 255);
        chk("dbz_r", out_remainder, 200);
        chk("dbz_flag", out_dbz, exp_dbz);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("dbz_pop_level", level, 0);
        chk("dbz_pop_flag", out_dbz, 0);

        // Reset mid-flight: three ops issued, reset pulsed at cycle 4
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            dividend = N'(90 + i);
            divisor  = 8'd4;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("mid_reserved_before", dut.reserved_q, 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * LAT; i++) begin
            step();
            chk("mid_no_result", out_valid, 0);
        end
        chk("mid_in_ready", in_ready, 1);
        chk("mid_level", level, 0);
        chk("mid_reserved", dut.reserved_q, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
